// File: rtl/bank_timing_tracker.sv
// Per-bank DDR3 state/timing tracker: NUM_BANKS independent bank machines plus a
// shared tRFC counter; reports per-bank command legality and row hit/conflict.

module bank_machine #(
   parameter int ROW_BITS = 14,
   parameter int CNT_W    = 8,
   parameter int TRCD     = 11,
   parameter int TRAS     = 28,
   parameter int TRP      = 11,
   parameter int TWR      = 12,
   parameter int TRTP     = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                act_go,
   input  logic                rd_go,
   input  logic                wr_go,
   input  logic                pre_go,
   input  logic [ROW_BITS-1:0] row,
   input  logic                rfc_zero,
   output logic [ROW_BITS-1:0] open_row,
   output logic                is_open,
   output logic                is_idle,
   output logic                act_ok,
   output logic                rw_ok,
   output logic                pre_ok
);
   typedef enum logic [1:0] {IDLE, OPENING, OPEN, CLOSING} bank_state_t;

   localparam logic [CNT_W-1:0] RCD_LD  = CNT_W'(TRCD - 1);
   localparam logic [CNT_W-1:0] RAS_LD  = CNT_W'(TRAS - 1);
   localparam logic [CNT_W-1:0] RP_LD   = CNT_W'(TRP - 1);
   localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(TWR - 1);
   localparam logic [CNT_W-1:0] RTP_LD  = CNT_W'(TRTP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   bank_state_t      state, state_nxt;
   logic [CNT_W-1:0] rcd_cnt, ras_cnt, pre_cnt, rp_cnt;
   logic [CNT_W-1:0] pre_dec;

   function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

   // State flips on the edge where the counter lands on 0, so the dependent
   // command is legal exactly T cycles after the accept (T==1 skips the wait state).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (act_go) state_nxt = (TRCD == 1) ? OPEN : OPENING;
         OPENING: if (rcd_cnt == CNT_ONE) state_nxt = OPEN;
         OPEN:    if (pre_go) state_nxt = (TRP == 1) ? IDLE : CLOSING;
         CLOSING: if (rp_cnt == CNT_ONE) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign pre_dec = dec(pre_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         open_row <= '0;
         rcd_cnt  <= '0;
         ras_cnt  <= '0;
         pre_cnt  <= '0;
         rp_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         rcd_cnt <= act_go ? RCD_LD : dec(rcd_cnt);
         ras_cnt <= act_go ? RAS_LD : dec(ras_cnt);
         rp_cnt  <= pre_go ? RP_LD  : dec(rp_cnt);
         if (act_go) open_row <= row;
         // An earlier, longer write-recovery window must not be shortened by a later read.
         if (wr_go)      pre_cnt <= (pre_dec > WR_LD)  ? pre_dec : WR_LD;
         else if (rd_go) pre_cnt <= (pre_dec > RTP_LD) ? pre_dec : RTP_LD;
         else            pre_cnt <= pre_dec;
      end
   end

   assign is_idle = (state == IDLE);
   assign is_open = (state == OPENING) || (state == OPEN);
   assign act_ok  = is_idle && rfc_zero;
   assign rw_ok   = (state == OPEN) && (rcd_cnt == '0);
   assign pre_ok  = is_idle || ((state == OPEN) && (ras_cnt == '0) && (pre_cnt == '0));
endmodule

module bank_timing_tracker #(
   parameter int NUM_BANKS = 8,
   parameter int BA_BITS   = 3,
   parameter int ROW_BITS  = 14,
   parameter int TRCD      = 11,
   parameter int TRAS      = 28,
   parameter int TRP       = 11,
   parameter int TWR       = 12,
   parameter int TRTP      = 6,
   parameter int TRFC      = 160,
   parameter int CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   input  logic [3:0]           cmd,
   input  logic [BA_BITS-1:0]   cmd_bank,
   input  logic [ROW_BITS-1:0]  cmd_row,
   output logic                 cmd_accept,
   output logic                 illegal,
   input  logic [BA_BITS-1:0]   q_bank,
   input  logic [ROW_BITS-1:0]  q_row,
   output logic                 q_hit,
   output logic                 q_conflict,
   output logic [NUM_BANKS-1:0] bank_open,
   output logic [NUM_BANKS-1:0] act_ok,
   output logic [NUM_BANKS-1:0] rw_ok,
   output logic [NUM_BANKS-1:0] pre_ok,
   output logic                 all_idle
);
   typedef enum logic [3:0] {
      NOP = 4'd0, READ = 4'd1, WRITE = 4'd2, POWER_D = 4'd3,
      POWER_U = 4'd4, REFRESH = 4'd5, ACTIVE = 4'd6, PRECHARGE = 4'd7
   } sch_cmd_t;

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   if ((TRCD - 1 > CNT_MAX) || (TRAS - 1 > CNT_MAX) || (TRP - 1 > CNT_MAX) ||
       (TWR - 1 > CNT_MAX) || (TRTP - 1 > CNT_MAX) || (TRFC - 1 > CNT_MAX)) begin : g_cnt_w_check
      $error("bank_timing_tracker: CNT_W too narrow for a timing parameter");
   end
   if ((1 << BA_BITS) != NUM_BANKS) begin : g_ba_check
      $error("bank_timing_tracker: BA_BITS must equal log2(NUM_BANKS)");
   end

   logic [NUM_BANKS-1:0][ROW_BITS-1:0] open_rows;
   logic [NUM_BANKS-1:0] bank_idle;
   logic [CNT_W-1:0]     rfc_cnt;
   logic                 rfc_zero;
   logic                 legal;

   assign rfc_zero = (rfc_cnt == '0);
   assign all_idle = (&bank_idle) && rfc_zero;

   // Legality is a pure function of registered per-bank flags plus the row compare.
   always_comb begin
      legal = 1'b0;
      case (cmd)
         NOP, POWER_D, POWER_U: legal = 1'b1;
         READ, WRITE:           legal = rw_ok[cmd_bank] && (open_rows[cmd_bank] == cmd_row);
         ACTIVE:                legal = act_ok[cmd_bank];
         PRECHARGE:             legal = pre_ok[cmd_bank];
         REFRESH:               legal = all_idle;
         default:               legal = 1'b0;
      endcase
   end

   assign cmd_accept = cmd_valid && legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal <= 1'b0;
         rfc_cnt <= '0;
      end else begin
         illegal <= cmd_valid && !legal;
         if (cmd_accept && (cmd == REFRESH)) rfc_cnt <= CNT_W'(TRFC - 1);
         else if (!rfc_zero)                 rfc_cnt <= rfc_cnt - 1'b1;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic sel;
      assign sel = cmd_accept && (cmd_bank == BA_BITS'(b));

      bank_machine #(
         .ROW_BITS(ROW_BITS), .CNT_W(CNT_W), .TRCD(TRCD), .TRAS(TRAS),
         .TRP(TRP), .TWR(TWR), .TRTP(TRTP)
      ) u_bank (
         .clk      (clk),
         .rst_n    (rst_n),
         .act_go   (sel && (cmd == ACTIVE)),
         .rd_go    (sel && (cmd == READ)),
         .wr_go    (sel && (cmd == WRITE)),
         .pre_go   (sel && (cmd == PRECHARGE)),
         .row      (cmd_row),
         .rfc_zero (rfc_zero),
         .open_row (open_rows[b]),
         .is_open  (bank_open[b]),
         .is_idle  (bank_idle[b]),
         .act_ok   (act_ok[b]),
         .rw_ok    (rw_ok[b]),
         .pre_ok   (pre_ok[b])
      );
   end

   assign q_hit      = bank_open[q_bank] && (open_rows[q_bank] == q_row);
   assign q_conflict = bank_open[q_bank] && (open_rows[q_bank] != q_row);
endmodule

// File: tb/tb_bank_timing_tracker.sv
// Directed bench for bank_timing_tracker: a per-cycle vector table from reset plus
// hand-written sequences for tRCD/tRAS/tRTP/tWR/tRP/tRFC and async reset.

module tb_bank_timing_tracker;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [3:0]  cmd;
   logic [2:0]  cmd_bank;
   logic [13:0] cmd_row;
   logic        cmd_accept, illegal;
   logic [2:0]  q_bank;
   logic [13:0] q_row;
   logic        q_hit, q_conflict;
   logic [7:0]  bank_open, act_ok, rw_ok, pre_ok;
   logic        all_idle;

   localparam logic [3:0] C_NOP = 4'd0, C_RD = 4'd1, C_WR = 4'd2, C_PD = 4'd3,
                          C_PU = 4'd4, C_REF = 4'd5, C_ACT = 4'd6, C_PRE = 4'd7;

   bank_timing_tracker dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
      .cmd_row(cmd_row), .cmd_accept(cmd_accept), .illegal(illegal), .q_bank(q_bank),
      .q_row(q_row), .q_hit(q_hit), .q_conflict(q_conflict), .bank_open(bank_open),
      .act_ok(act_ok), .rw_ok(rw_ok), .pre_ok(pre_ok), .all_idle(all_idle)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cur   = -1;

   typedef struct {
      logic       v;
      logic [3:0] c;
      logic [2:0] b;
      logic [13:0] r;
      logic       e_acc;
      logic       e_ill;
      logic [7:0] e_open;
      logic [7:0] e_act;
      logic [7:0] e_rw;
      logic [7:0] e_pre;
      logic       e_idle;
      logic       e_hit;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cur, a, e);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = C_NOP; cmd_bank = '0; cmd_row = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cur = -1;
   endtask

   // One cycle: drive at the falling edge, outputs settle 1ns later.
   task automatic cyc(input logic v, input logic [3:0] c, input logic [2:0] b, input logic [13:0] r);
      @(negedge clk);
      cmd_valid = v; cmd = c; cmd_bank = b; cmd_row = r;
      cur++;
      #1;
   endtask

   task automatic at(input int k, input logic v, input logic [3:0] c, input logic [2:0] b,
                     input logic [13:0] r);
      while (cur < k - 1) cyc(1'b0, C_NOP, 3'd0, 14'd0);
      cyc(v, c, b, r);
   endtask

   initial begin
      // PRE/NOP/power to idle banks, an undefined opcode, then an ACT and illegal follow-ups.
      vecs[0]  = '{1, C_PRE, 4, 14'h0,  1, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[1]  = '{1, C_NOP, 0, 14'h0,  1, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[2]  = '{1, C_PD,  0, 14'h0,  1, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[3]  = '{1, 4'd9,  0, 14'h0,  0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[4]  = '{1, C_PU,  0, 14'h0,  1, 1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[5]  = '{0, 4'd9,  0, 14'h0,  0, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[6]  = '{1, C_ACT, 5, 14'h33, 1, 0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1, 0};
      vecs[7]  = '{1, C_RD,  5, 14'h33, 0, 0, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[8]  = '{0, C_NOP, 0, 14'h0,  0, 1, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[9]  = '{1, C_PRE, 5, 14'h0,  0, 0, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[10] = '{1, C_ACT, 5, 14'h33, 0, 1, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[11] = '{1, C_REF, 0, 14'h0,  0, 1, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[12] = '{1, C_NOP, 0, 14'h0,  1, 1, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};
      vecs[13] = '{1, C_NOP, 0, 14'h0,  1, 0, 8'h20, 8'hDF, 8'h00, 8'hDF, 0, 1};

      q_bank = 3'd5; q_row = 14'h33;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         cyc(vecs[i].v, vecs[i].c, vecs[i].b, vecs[i].r);
         chk($sformatf("vec%0d accept", i),   32'(cmd_accept), 32'(vecs[i].e_acc));
         chk($sformatf("vec%0d illegal", i),  32'(illegal),    32'(vecs[i].e_ill));
         chk($sformatf("vec%0d bank_open", i), 32'(bank_open), 32'(vecs[i].e_open));
         chk($sformatf("vec%0d act_ok", i),   32'(act_ok),     32'(vecs[i].e_act));
         chk($sformatf("vec%0d rw_ok", i),    32'(rw_ok),      32'(vecs[i].e_rw));
         chk($sformatf("vec%0d pre_ok", i),   32'(pre_ok),     32'(vecs[i].e_pre));
         chk($sformatf("vec%0d all_idle", i), 32'(all_idle),   32'(vecs[i].e_idle));
         chk($sformatf("vec%0d q_hit", i),    32'(q_hit),      32'(vecs[i].e_hit));
         chk($sformatf("vec%0d q_conflict", i), 32'(q_conflict), 32'd0);
      end

      // tRCD window and row-mismatch read
      do_reset();
      at(0, 1, C_ACT, 2, 14'h1A5);
      chk("A act accept", 32'(cmd_accept), 32'd1);
      for (int k = 1; k <= 10; k++) begin
         at(k, 0, C_NOP, 0, 0);
         chk("A open2", 32'(bank_open[2]), 32'd1);
         chk("A rw2 early", 32'(rw_ok[2]), 32'd0);
         if (k == 1) begin
            q_bank = 3'd2; q_row = 14'h1A5; #1;
            chk("A q_hit", 32'(q_hit), 32'd1);
            q_row = 14'h1A6; #1;
            chk("A q_conflict", 32'(q_conflict), 32'd1);
            chk("A q_hit off", 32'(q_hit), 32'd0);
         end
      end
      at(11, 1, C_RD, 2, 14'h1A6);
      chk("A rw2 at 11", 32'(rw_ok[2]), 32'd1);
      chk("A bad row reject", 32'(cmd_accept), 32'd0);
      at(12, 0, C_NOP, 0, 0);
      chk("A illegal pulse", 32'(illegal), 32'd1);
      at(13, 1, C_RD, 2, 14'h1A5);
      chk("A good row read", 32'(cmd_accept), 32'd1);
      chk("A illegal one cycle", 32'(illegal), 32'd0);

      // tRAS, tRTP and tRP
      do_reset();
      at(0, 1, C_ACT, 0, 14'd7);
      at(11, 1, C_RD, 0, 14'd7);
      chk("B read accept", 32'(cmd_accept), 32'd1);
      at(27, 1, C_PRE, 0, 0);
      chk("B pre t27 reject", 32'(cmd_accept), 32'd0);
      at(28, 1, C_PRE, 0, 0);
      chk("B pre t28 accept", 32'(cmd_accept), 32'd1);
      at(38, 0, C_NOP, 0, 0);
      chk("B act0 t38", 32'(act_ok[0]), 32'd0);
      at(39, 0, C_NOP, 0, 0);
      chk("B act0 t39", 32'(act_ok[0]), 32'd1);

      // tWR dominates tRAS
      do_reset();
      at(0, 1, C_ACT, 1, 14'd3);
      at(20, 1, C_WR, 1, 14'd3);
      chk("C write accept", 32'(cmd_accept), 32'd1);
      at(28, 0, C_NOP, 0, 0);
      chk("C pre1 t28", 32'(pre_ok[1]), 32'd0);
      at(31, 0, C_NOP, 0, 0);
      chk("C pre1 t31", 32'(pre_ok[1]), 32'd0);
      at(32, 0, C_NOP, 0, 0);
      chk("C pre1 t32", 32'(pre_ok[1]), 32'd1);

      // REFRESH gating and tRFC
      do_reset();
      at(0, 1, C_ACT, 3, 14'd0);
      at(1, 1, C_REF, 0, 0);
      chk("D ref while open", 32'(cmd_accept), 32'd0);
      at(2, 0, C_NOP, 0, 0);
      chk("D ref illegal", 32'(illegal), 32'd1);
      at(28, 1, C_PRE, 3, 0);
      chk("D pre accept", 32'(cmd_accept), 32'd1);
      at(38, 0, C_NOP, 0, 0);
      chk("D idle t38", 32'(all_idle), 32'd0);
      at(39, 1, C_REF, 0, 0);
      chk("D ref accept", 32'(cmd_accept), 32'd1);
      at(40, 0, C_NOP, 0, 0);
      chk("D act t+1", 32'(act_ok), 32'h00);
      chk("D idle t+1", 32'(all_idle), 32'd0);
      at(198, 0, C_NOP, 0, 0);
      chk("D act t+159", 32'(act_ok), 32'h00);
      at(199, 0, C_NOP, 0, 0);
      chk("D act t+160", 32'(act_ok), 32'hFF);
      chk("D idle t+160", 32'(all_idle), 32'd1);

      // Interleaved ACTs: each bank's rw_ok rises 11 cycles after its own ACT
      do_reset();
      for (int c = 0; c < 20; c++) begin
         logic [7:0] exp_rw;
         if (c < 8) at(c, 1, C_ACT, 3'(c), 14'(c));
         else       at(c, 0, C_NOP, 0, 0);
         exp_rw = '0;
         for (int k = 0; k < 8; k++) if (c >= k + 11) exp_rw[k] = 1'b1;
         chk($sformatf("E rw_ok c%0d", c), 32'(rw_ok), 32'(exp_rw));
      end

      // Asynchronous reset mid-operation
      do_reset();
      for (int k = 0; k < 4; k++) at(k, 1, C_ACT, 3'(k), 14'(k + 1));
      at(4, 1, 4'd9, 0, 0);
      at(5, 0, C_NOP, 0, 0);
      chk("F open before rst", 32'(bank_open), 32'h0F);
      chk("F illegal before rst", 32'(illegal), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("F rst bank_open", 32'(bank_open), 32'h00);
      chk("F rst act_ok", 32'(act_ok), 32'hFF);
      chk("F rst rw_ok", 32'(rw_ok), 32'h00);
      chk("F rst pre_ok", 32'(pre_ok), 32'hFF);
      chk("F rst all_idle", 32'(all_idle), 32'd1);
      chk("F rst illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
